palette_encoder: RTL and testbench

- Converts a stream of 24-bit RGB pixels into 4-bit palette indices, using the same 16-entry palette the VGA colour mapper decodes.
- Packs four indices per 16-bit word and writes the words sequentially into the sprite/frame memory through a valid/ready write port.
- Used at load time to turn RGB sprite and asset data into the palette-indexed format the draw path reads back and feeds to the colour mapper.

---
 rtl/palette_encoder.sv | 146 ++++++++++++++
 tb/tb_palette_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_encoder.sv
// RGB888 to 4-bit palette index encoder: packs four indices per 16-bit word and
// streams the words to the sprite/frame memory over a valid/ready write port.
module palette_encoder #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned FRAME_WORDS = 76800
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_r,
   input  logic [7:0]        in_g,
   input  logic [7:0]        in_b,
   input  logic              in_last,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              wr_last,
   output logic              frame_done,
   output logic [15:0]       miss_count,
   output logic              err_overrun
);

   localparam int unsigned CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_WORDS - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   // Same table the VGA colour mapper decodes; 9..12 alias AAAAAA, 15 is transparent.
   localparam logic [23:0] PALETTE [16] = '{
      24'hFFFFFF, 24'h0E0E0E, 24'h3B3B3B, 24'h2195F3,
      24'h00BBD4, 24'hCF1010, 24'hFF5252, 24'h242424,
      24'h161616, 24'hAAAAAA, 24'hAAAAAA, 24'hAAAAAA,
      24'hAAAAAA, 24'h00710E, 24'h000000, 24'hF200FF
   };

   logic             r_a_valid;
   logic [23:0]      r_a_rgb;
   logic             r_a_last;
   logic [1:0]       r_slot;
   logic [15:0]      r_pack;
   logic             r_new_frame;
   logic [CNT_W-1:0] r_word_cnt;

   logic             w_advance;
   logic             w_xfer;
   logic             w_accept;
   logic             w_word_done;
   logic             w_hit;
   logic [3:0]       w_idx;
   logic [15:0]      w_packed;

   assign w_advance   = !(wr_valid && !wr_ready);
   assign in_ready    = w_advance && !Reset;
   assign w_xfer      = in_valid && in_ready;
   assign w_accept    = wr_valid && wr_ready;
   assign w_word_done = r_a_valid && ((r_slot == 2'd3) || r_a_last);

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      w_idx = 4'hF;
      w_hit = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (r_a_rgb == PALETTE[i]) begin
            w_idx = 4'(i);
            w_hit = 1'b1;
         end
      end
   end

   // Unfilled slots of r_pack stay at F, which doubles as the pad for short words.
   always_comb begin
      w_packed = r_pack;
      w_packed[{r_slot, 2'b00} +: 4] = w_idx;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_a_valid   <= 1'b0;
         r_a_rgb     <= 24'h0;
         r_a_last    <= 1'b0;
         r_slot      <= 2'd0;
         r_pack      <= 16'hFFFF;
         r_new_frame <= 1'b1;
         r_word_cnt  <= '0;
         wr_valid    <= 1'b0;
         wr_addr     <= BASE;
         wr_data     <= 16'h0;
         wr_last     <= 1'b0;
         frame_done  <= 1'b0;
         miss_count  <= 16'h0;
         err_overrun <= 1'b0;
      end else begin
         frame_done <= w_accept && wr_last;

         // Address walks the frame; wraps on last word or after FRAME_WORDS words.
         if (w_accept) begin
            if (wr_last || (r_word_cnt == LAST_CNT)) begin
               wr_addr    <= BASE;
               r_word_cnt <= '0;
               if (!wr_last) begin
                  err_overrun <= 1'b1;
               end
            end else begin
               wr_addr    <= wr_addr + ADDR_W'(1);
               r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
         end

         if (w_advance) begin
            r_a_valid <= w_xfer;
            if (w_xfer) begin
               r_a_rgb  <= {in_r, in_g, in_b};
               r_a_last <= in_last;
            end

            if (r_a_valid) begin
               r_new_frame <= r_a_last;
               if (r_new_frame) begin
                  miss_count <= {15'h0, !w_hit};
               end else if (!w_hit && (miss_count != 16'hFFFF)) begin
                  miss_count <= miss_count + 16'(1);
               end

               if (w_word_done) begin
                  wr_data  <= w_packed;
                  wr_last  <= r_a_last;
                  wr_valid <= 1'b1;
                  r_pack   <= 16'hFFFF;
                  r_slot   <= 2'd0;
               end else begin
                  wr_valid <= 1'b0;
                  wr_last  <= 1'b0;
                  r_pack   <= w_packed;
                  r_slot   <= r_slot + 2'd1;
               end
            end else begin
               wr_valid <= 1'b0;
               wr_last  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder: table of one-word frames plus hand-written
// sequences for multi-word frames, backpressure, overrun wrap and mid-word reset.
module tb_palette_encoder;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        wr_ready = 1'b1;
   logic [7:0]  in_r = 8'h0, in_g = 8'h0, in_b = 8'h0;

   logic        in_ready, wr_valid, wr_last, frame_done, err_overrun;
   logic [19:0] wr_addr;
   logic [15:0] wr_data, miss_count;

   logic        in_ready2, wr_valid2, wr_last2, frame_done2, err_overrun2;
   logic [19:0] wr_addr2;
   logic [15:0] wr_data2, miss_count2;

   always #5 Clk = ~Clk;

   palette_encoder dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_last(wr_last), .frame_done(frame_done), .miss_count(miss_count),
      .err_overrun(err_overrun)
   );

   palette_encoder #(.FRAME_WORDS(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
      .wr_valid(wr_valid2), .wr_ready(wr_ready), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .wr_last(wr_last2), .frame_done(frame_done2), .miss_count(miss_count2),
      .err_overrun(err_overrun2)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [19:0] addr;
      logic        last;
   } wr_t;

   typedef struct packed {
      logic [23:0] p0, p1, p2, p3;
      logic [2:0]  n;
      logic [15:0] data;
      logic [15:0] miss;
   } vec_t;

   wr_t  q1[$];
   wr_t  q2[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   fd_count = 0;
   int   xfer_cyc = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Words are logged on the falling edge ahead of the rising edge that accepts them.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (wr_valid && wr_ready)  q1.push_back({wr_data, wr_addr, wr_last});
         if (wr_valid2 && wr_ready) q2.push_back({wr_data2, wr_addr2, wr_last2});
         if (frame_done) fd_count++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [23:0] rgb, input logic last);
      int n;
      n = 0;
      {in_r, in_g, in_b} = rgb;
      in_last  = last;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge Clk);
         #1;
         n++;
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      xfer_cyc = cyc;
      @(negedge Clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_q(input int sel, input int n);
      int k;
      k = 0;
      while (((sel == 1) ? q1.size() : q2.size()) < n && k < 100) begin
         @(negedge Clk);
         k++;
      end
      chk("wait_words", 32'((sel == 1) ? q1.size() : q2.size()) >= 32'(n) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge Clk);
   endtask

   task automatic chk_word(input string name, input wr_t w, input logic [15:0] d,
                           input logic [19:0] a, input logic l);
      chk({name, "_data"}, 32'(w.data), 32'(d));
      chk({name, "_addr"}, 32'(w.addr), 32'(a));
      chk({name, "_last"}, 32'(w.last), 32'(l));
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_wr_valid"}, 32'(wr_valid), 32'd0);
      chk({name, "_wr_last"}, 32'(wr_last), 32'd0);
      chk({name, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({name, "_miss"}, 32'(miss_count), 32'd0);
      chk({name, "_err"}, 32'(err_overrun), 32'd0);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      q1.delete();
      q2.delete();
   endtask

   vec_t        tbl[7];
   wr_t         w;
   logic [23:0] px[4];
   int          n, fd0;

   initial begin
      tbl[0] = {24'hFFFFFF, 24'h2195F3, 24'hCF1010, 24'hF200FF, 3'd4, 16'hF530, 16'd0};
      tbl[1] = {24'h123456, 24'h000000, 24'h000000, 24'h000000, 3'd4, 16'hEEEF, 16'd1};
      tbl[2] = {24'h0E0E0E, 24'h3B3B3B, 24'h00BBD4, 24'hFF5252, 3'd4, 16'h6421, 16'd0};
      tbl[3] = {24'h242424, 24'h161616, 24'hAAAAAA, 24'h00710E, 3'd4, 16'hD987, 16'd0};
      tbl[4] = {24'h010203, 24'hFFFFFE, 24'hAAAAAA, 24'hF200FE, 3'd4, 16'hF9FF, 16'd3};
      tbl[5] = {24'h00BBD4, 24'h000000, 24'h000000, 24'h000000, 3'd1, 16'hFFF4, 16'd0};
      tbl[6] = {24'hCF1010, 24'h000000, 24'h123456, 24'h000000, 3'd3, 16'hFFE5, 16'd1};

      // Reset state, sampled while Reset is still high.
      repeat (2) @(negedge Clk);
      chk_reset_vals("reset");
      Reset = 1'b0;
      @(negedge Clk);

      // First word and its latency after the 4th accept.
      send(24'hFFFFFF, 1'b0);
      send(24'h2195F3, 1'b0);
      send(24'hCF1010, 1'b0);
      send(24'hF200FF, 1'b0);
      n = 0;
      while (!wr_valid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk("latency", 32'(cyc - xfer_cyc), 32'd2);
      wait_q(1, 1);
      w = q1.pop_front();
      chk_word("first", w, 16'hF530, 20'd0, 1'b0);
      chk("first_miss", 32'(miss_count), 32'd0);
      do_reset();

      // Two-word frame with a padded final word.
      fd0 = fd_count;
      for (int i = 0; i < 6; i++) send(24'hAAAAAA, i == 5);
      wait_q(1, 2);
      w = q1.pop_front();
      chk_word("aaaa0", w, 16'h9999, 20'd0, 1'b0);
      w = q1.pop_front();
      chk_word("aaaa1", w, 16'hFF99, 20'd1, 1'b1);
      chk("aaaa_frame_done", 32'(fd_count - fd0), 32'd1);
      chk("aaaa_addr_back", 32'(wr_addr), 32'd0);

      // One-word frames from the table.
      for (int i = 0; i < 7; i++) begin
         px[0] = tbl[i].p0;
         px[1] = tbl[i].p1;
         px[2] = tbl[i].p2;
         px[3] = tbl[i].p3;
         fd0 = fd_count;
         for (int j = 0; j < int'(tbl[i].n); j++) send(px[j], j == int'(tbl[i].n) - 1);
         wait_q(1, 1);
         w = q1.pop_front();
         chk_word($sformatf("vec%0d", i), w, tbl[i].data, 20'd0, 1'b1);
         chk($sformatf("vec%0d_miss", i), 32'(miss_count), 32'(tbl[i].miss));
         chk($sformatf("vec%0d_done", i), 32'(fd_count - fd0), 32'd1);
      end

      // Backpressure: output held for 5 cycles while the pipeline fills.
      wr_ready = 1'b0;
      fork
         begin
            send(24'hFFFFFF, 1'b0);
            send(24'h0E0E0E, 1'b0);
            send(24'h3B3B3B, 1'b0);
            send(24'h2195F3, 1'b0);
            send(24'h00BBD4, 1'b0);
            send(24'hCF1010, 1'b0);
            send(24'hFF5252, 1'b0);
            send(24'h242424, 1'b1);
         end
         begin
            n = 0;
            while (!wr_valid && n < 50) begin
               @(negedge Clk);
               n++;
            end
            repeat (5) begin
               @(negedge Clk);
               chk("stall_valid", 32'(wr_valid), 32'd1);
               chk("stall_data", 32'(wr_data), 32'h3210);
               chk("stall_addr", 32'(wr_addr), 32'd0);
            end
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge Clk);
            wr_ready = 1'b1;
         end
      join
      wait_q(1, 2);
      w = q1.pop_front();
      chk_word("stall0", w, 16'h3210, 20'd0, 1'b0);
      w = q1.pop_front();
      chk_word("stall1", w, 16'h7654, 20'd1, 1'b1);
      chk("last_on_limit_no_err", 32'(err_overrun2), 32'd0);

      // Overrun: FRAME_WORDS=2 instance wraps on the third word.
      do_reset();
      for (int i = 0; i < 12; i++) send(24'h000000, 1'b0);
      wait_q(2, 3);
      w = q2.pop_front();
      chk_word("ovr0", w, 16'hEEEE, 20'd0, 1'b0);
      w = q2.pop_front();
      chk_word("ovr1", w, 16'hEEEE, 20'd1, 1'b0);
      w = q2.pop_front();
      chk_word("ovr2", w, 16'hEEEE, 20'd0, 1'b0);
      chk("ovr_err", 32'(err_overrun2), 32'd1);
      chk("big_frame_no_err", 32'(err_overrun), 32'd0);
      chk("big_frame_addr", 32'(wr_addr), 32'd3);
      repeat (5) @(negedge Clk);
      chk("ovr_err_sticky", 32'(err_overrun2), 32'd1);

      // Reset mid-word discards the partial word.
      do_reset();
      for (int i = 0; i < 4; i++) send(24'h123456, 1'b0);
      wait_q(1, 1);
      w = q1.pop_front();
      chk_word("pre_rst", w, 16'hFFFF, 20'd0, 1'b0);
      chk("pre_rst_miss", 32'(miss_count), 32'd4);
      send(24'hFFFFFF, 1'b0);
      send(24'hFFFFFF, 1'b0);
      Reset = 1'b1;
      @(negedge Clk);
      chk_reset_vals("midrst");
      chk("midrst_err2", 32'(err_overrun2), 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      send(24'hFF5252, 1'b0);
      send(24'h00710E, 1'b0);
      send(24'hF200FF, 1'b0);
      send(24'hFFFFFF, 1'b1);
      wait_q(1, 1);
      w = q1.pop_front();
      chk_word("post_rst", w, 16'h0FD6, 20'd0, 1'b1);
      chk("post_rst_extra", 32'(q1.size()), 32'd0);
      chk("post_rst_miss", 32'(miss_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
